wspr_symbol_scheduler: RTL and testbench

//  Sequences one WSPR transmission: fetches NUM_SYMBOLS 2-bit tone symbols from the encoder over a req/ack handshake.

---
 rtl/wspr_symbol_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_wspr_symbol_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wspr_symbol_scheduler.sv
// ---------------------------------------------------------------------------
// wspr_symbol_scheduler
//
// Sequences one WSPR transmission. NUM_SYMBOLS 2-bit tone symbols are pulled
// from the encoder over a sym_req/sym_ack handshake. Each symbol is presented
// on `tone` for exactly TICKS_PER_SYMBOL clocks, and the RF oscillator enable
// is gated around the whole transmission. While one symbol is on air, the
// next one is prefetched so that symbol boundaries are seamless.
//
// Optional feature macro: WSPR_REPEAT_EN
//   When defined, a finished transmission enters a GAP state instead of IDLE.
//   GAP lasts REPEAT_GAP symbol periods with RF off and tx_active still high.
//   After GAP the next transmission is fetched automatically.
//   When undefined, done always returns to IDLE and REPEAT_GAP is unused.
//
// Parameters
//   TICKS_PER_SYMBOL  clocks per symbol (>= 2)
//   NUM_SYMBOLS       symbols per transmission (1..256)
//   REPEAT_GAP        idle symbol periods between auto-repeats
//
// Ports
//   clk        in   system clock
//   rst_n      in   synchronous reset, active low
//   start      in   one-cycle pulse; begins a transmission when idle
//   abort      in   level; terminates any activity
//   sym_req    out  request for the next symbol from the encoder
//   sym_ack    in   encoder presents sym_data (only honoured while sym_req=1)
//   sym_data   in   tone index 0..3
//   tone       out  current tone index to the NCO
//   rf_en      out  RF output enable
//   tx_active  out  high from accepted start until IDLE is re-entered
//   sym_idx    out  index of the symbol currently on tone
//   done       out  one-cycle pulse after the last symbol completes
//   underrun   out  sticky: encoder missed a symbol boundary; cleared by start
// ---------------------------------------------------------------------------
module wspr_symbol_scheduler #(
  parameter int TICKS_PER_SYMBOL = 6826667,
  parameter int NUM_SYMBOLS      = 162,
  parameter int REPEAT_GAP       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       sym_req,
  input  logic       sym_ack,
  input  logic [1:0] sym_data,
  output logic [1:0] tone,
  output logic       rf_en,
  output logic       tx_active,
  output logic [7:0] sym_idx,
  output logic       done,
  output logic       underrun
);

  localparam int              PRE_W    = $clog2(TICKS_PER_SYMBOL);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SYMBOL - 1);
  localparam logic [7:0]      LAST_IDX = 8'(NUM_SYMBOLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH0 = 2'd1,
    S_TX     = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t            state;
  logic [PRE_W-1:0]  prescaler;
  logic [1:0]        next_tone;
  logic              next_valid;
  logic              ack_ok;
  logic [7:0]        idx_inc;

`ifdef WSPR_REPEAT_EN
  localparam int              GAP_LEN = REPEAT_GAP * TICKS_PER_SYMBOL;
  localparam int              GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0]  gap_cnt;
`else
  // Keeps the repeat-gap parameter referenced when the repeat feature is
  // compiled out, so the parameter list is identical in both builds.
  logic [31:0] unused_repeat_gap;
  assign unused_repeat_gap = 32'(REPEAT_GAP);
`endif

  // An ack only counts while a request is outstanding.
  assign ack_ok  = sym_req & sym_ack;
  assign idx_inc = sym_idx + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prescaler  <= '0;
      sym_idx    <= '0;
      tone       <= '0;
      next_tone  <= '0;
      next_valid <= 1'b0;
      sym_req    <= 1'b0;
      rf_en      <= 1'b0;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
`ifdef WSPR_REPEAT_EN
      gap_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort wins over start, boundaries and the done pulse.
        state      <= S_IDLE;
        prescaler  <= '0;
        sym_req    <= 1'b0;
        rf_en      <= 1'b0;
        tone       <= '0;
        tx_active  <= 1'b0;
        next_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_FETCH0;
              tx_active <= 1'b1;
              sym_req   <= 1'b1;
              underrun  <= 1'b0;
            end
          end

          S_FETCH0: begin
            if (ack_ok) begin
              state      <= S_TX;
              tone       <= sym_data;
              sym_idx    <= '0;
              rf_en      <= 1'b1;
              prescaler  <= '0;
              next_valid <= 1'b0;
              // Prefetch of symbol 1 starts right away if it exists.
              sym_req    <= (LAST_IDX != 8'd0);
            end
          end

          S_TX: begin
            if (prescaler == PRE_MAX) begin
              if (sym_idx == LAST_IDX) begin
                done       <= 1'b1;
                rf_en      <= 1'b0;
                tone       <= '0;
                sym_req    <= 1'b0;
                next_valid <= 1'b0;
                prescaler  <= '0;
`ifdef WSPR_REPEAT_EN
                state      <= S_GAP;
                gap_cnt    <= '0;
`else
                state      <= S_IDLE;
                tx_active  <= 1'b0;
`endif
              end else if (ack_ok || next_valid) begin
                // A same-cycle ack is taken directly from sym_data.
                tone       <= ack_ok ? sym_data : next_tone;
                sym_idx    <= idx_inc;
                prescaler  <= '0;
                next_valid <= 1'b0;
                sym_req    <= (idx_inc != LAST_IDX);
              end else begin
                // Encoder is late: freeze at the boundary, keep the old tone
                // on air, and load as soon as the ack arrives. The late
                // symbol then still gets a full period.
                underrun <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
              if (ack_ok) begin
                next_tone  <= sym_data;
                next_valid <= 1'b1;
                sym_req    <= 1'b0;
              end
            end
          end

`ifdef WSPR_REPEAT_EN
          S_GAP: begin
            // RF stays off, tx_active stays high; start is ignored here.
            if (gap_cnt == GAP_MAX) begin
              state   <= S_FETCH0;
              sym_req <= 1'b1;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
`endif

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wspr_symbol_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wspr_symbol_scheduler
//
// Bench for wspr_symbol_scheduler with TICKS_PER_SYMBOL=4, NUM_SYMBOLS=3,
// REPEAT_GAP=1. A single process drives the inputs on the falling edge,
// plays the encoder (configurable or random ack latency, optional stray
// acks), and advances a transaction-level reference model. The model tracks
// the transmission as a phase, a countdown of ticks left in the current
// symbol and a queue of prefetched symbols. Every cycle all DUT outputs are
// compared with the model, and a few directed scenarios add explicit checks.
// ---------------------------------------------------------------------------
module tb_wspr_symbol_scheduler;

  localparam int TPS  = 4;
  localparam int NSYM = 3;
  localparam int RGAP = 1;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_TX    = 2;
  localparam int P_GAP   = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       sym_req, sym_ack;
  logic [1:0] sym_data, tone;
  logic       rf_en, tx_active, done, underrun;
  logic [7:0] sym_idx;

  always #5 clk = ~clk;

  wspr_symbol_scheduler #(
    .TICKS_PER_SYMBOL(TPS),
    .NUM_SYMBOLS     (NSYM),
    .REPEAT_GAP      (RGAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .sym_req  (sym_req),
    .sym_ack  (sym_ack),
    .sym_data (sym_data),
    .tone     (tone),
    .rf_en    (rf_en),
    .tx_active(tx_active),
    .sym_idx  (sym_idx),
    .done     (done),
    .underrun (underrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: predicted outputs after the next rising edge.
  int         m_phase = P_IDLE;
  int         m_left  = 0;
  int         m_gap   = 0;
  logic       m_req   = 1'b0;
  logic       m_rf    = 1'b0;
  logic       m_act   = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_und   = 1'b0;
  logic [1:0] m_tone  = 2'd0;
  logic [7:0] m_idx   = 8'd0;
  logic [1:0] m_pend[$];

  // Encoder behaviour.
  int   enc_fixed = 1;
  int   enc_wait  = 0;
  int   enc_dly   = 1;
  logic spur_en   = 1'b0;

  logic chk_en   = 1'b0;
  int   done_cnt = 0;

  function automatic int pick_delay();
    if (enc_fixed >= 0) return enc_fixed;
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
    return int'($urandom_range(4, 10));
  endfunction

  task automatic m_load(input logic [1:0] d, input int i);
    m_phase = P_TX;
    m_tone  = d;
    m_idx   = 8'(i);
    m_rf    = 1'b1;
    m_left  = TPS;
    m_req   = (i < NSYM - 1);
    m_pend.delete();
  endtask

  // Advance the model by one rising edge using the inputs just driven.
  task automatic m_step();
    logic got;
    got    = m_req && sym_ack;
    m_done = 1'b0;
    if (!rst_n) begin
      m_phase = P_IDLE; m_req = 0; m_rf = 0; m_act = 0; m_und = 0;
      m_tone = 0; m_idx = 0; m_left = 0;
      m_pend.delete();
    end else if (abort) begin
      m_phase = P_IDLE; m_req = 0; m_rf = 0; m_act = 0; m_tone = 0;
      m_pend.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase = P_FETCH; m_act = 1; m_req = 1; m_und = 0;
        end
        P_FETCH: if (got) m_load(sym_data, 0);
        P_TX: begin
          if (m_left > 1) begin
            m_left--;
            if (got) begin
              m_pend.push_back(sym_data);
              m_req = 0;
            end
          end else if (int'(m_idx) == NSYM - 1) begin
            m_done = 1; m_rf = 0; m_tone = 0; m_req = 0;
            m_pend.delete();
`ifdef WSPR_REPEAT_EN
            m_phase = P_GAP;
            m_gap   = RGAP * TPS;
`else
            m_phase = P_IDLE;
            m_act   = 0;
`endif
          end else if (got) begin
            m_load(sym_data, int'(m_idx) + 1);
          end else if (m_pend.size() > 0) begin
            m_load(m_pend.pop_front(), int'(m_idx) + 1);
          end else begin
            m_und = 1;
          end
        end
        P_GAP: begin
          m_gap--;
          if (m_gap == 0) begin
            m_phase = P_FETCH;
            m_req   = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: compare outputs, play the encoder, drive control, step model.
  task automatic tick(input logic r, input logic s, input logic a);
    @(negedge clk);
    if (chk_en) begin
      check_eq("sym_req",   sym_req,   m_req);
      check_eq("tone",      tone,      m_tone);
      check_eq("rf_en",     rf_en,     m_rf);
      check_eq("tx_active", tx_active, m_act);
      check_eq("sym_idx",   sym_idx,   m_idx);
      check_eq("done",      done,      m_done);
      check_eq("underrun",  underrun,  m_und);
    end
    if (done === 1'b1) done_cnt++;

    if (sym_ack) begin
      enc_wait = 0;
      enc_dly  = pick_delay();
    end
    if (sym_req) begin
      if (enc_wait >= enc_dly) begin
        sym_ack  = 1'b1;
        sym_data = 2'($urandom_range(0, 3));
      end else begin
        sym_ack = 1'b0;
        enc_wait++;
      end
    end else begin
      enc_wait = 0;
      enc_dly  = pick_delay();
      sym_ack  = spur_en && ($urandom_range(0, 9) == 0);
      sym_data = 2'($urandom_range(0, 3));
    end

    rst_n = r;
    start = s;
    abort = a;
    m_step();
  endtask

  task automatic go_idle();
    tick(1, 0, 1);
    tick(1, 0, 0);
  endtask

  initial begin
    int snap;
    rst_n = 0; start = 0; abort = 0; sym_ack = 0; sym_data = 0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk_en = 1'b1;
    tick(0, 0, 0);
    tick(1, 0, 0);
    check_eq("reset_tx_active", tx_active, 0);
    check_eq("reset_rf_en", rf_en, 0);

    // Plain transmission, ack one cycle after each request.
    enc_fixed = 1;
    done_cnt  = 0;
    tick(1, 1, 0);
    repeat (16) tick(1, 0, 0);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_rf_off", rf_en, 0);
    go_idle();

    // Slow encoder causes underrun; reset during TX then clears everything.
    enc_fixed = 9;
    tick(1, 1, 0);
    repeat (20) tick(1, 0, 0);
    check_eq("t2_underrun", underrun, 1);
    check_eq("t2_rf_on", rf_en, 1);
    tick(0, 0, 0);
    tick(1, 0, 0);
    check_eq("t5_underrun_clr", underrun, 0);
    check_eq("t5_rf_off", rf_en, 0);
    check_eq("t5_tone", tone, 0);

    // Abort in the middle of symbol 1.
    enc_fixed = 0;
    tick(1, 1, 0);
    repeat (7) tick(1, 0, 0);
    snap = done_cnt;
    tick(1, 0, 1);
    tick(1, 0, 0);
    check_eq("t3_rf_en", rf_en, 0);
    check_eq("t3_tone", tone, 0);
    check_eq("t3_sym_req", sym_req, 0);
    check_eq("t3_tx_active", tx_active, 0);
    repeat (12) tick(1, 0, 0);
    check_eq("t3_no_done", done_cnt, snap);

    // start+abort together in IDLE, then start during TX.
    tick(1, 1, 1);
    tick(1, 0, 0);
    check_eq("t4_stay_idle", tx_active, 0);
    check_eq("t4_no_req", sym_req, 0);
    tick(1, 1, 0);
    repeat (5) tick(1, 0, 0);
    tick(1, 1, 0);
    repeat (12) tick(1, 0, 0);
    go_idle();

    // Randomized traffic.
    enc_fixed = -1;
    spur_en   = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic r, s, a;
      r = ($urandom_range(0, 299) != 0);
      s = (m_phase == P_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
      a = ($urandom_range(0, 149) == 0);
      tick(r, s, a);
    end
    tick(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
